eth_rx_dispatch: RTL and testbench

ETH_RX_DISPATCH -- requirements
Module: eth_rx_dispatch

---
 rtl/eth_rx_dispatch.sv | 186 ++++++++++++++++++
 tb/tb_eth_rx_dispatch.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_dispatch.sv
// Receive-side frame dispatcher: filters on destination address and length, writes
// accepted bytes into a two-slot buffer RAM and presents committed frames in order.
module eth_rx_dispatch #(
  parameter logic [47:0] MAC     = 48'h02_00_00_00_00_01,
  parameter int          MAX_LEN = 1522,
  parameter int          MIN_LEN = 64
) (
  input  logic        c,
  input  logic        rst,
  input  logic [7:0]  rxd,
  input  logic        rxdv,
  input  logic        rxe,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_valid,
  output logic        frame_slot,
  output logic [10:0] frame_len,
  input  logic        frame_ack,
  output logic [15:0] drop_cnt
);

  localparam logic [10:0] MaxLen = 11'(MAX_LEN);
  localparam logic [10:0] MinLen = 11'(MIN_LEN);

  typedef enum logic [2:0] {IDLE, HDR, BODY, DROP, COMMIT} state_e;

  state_e      state_q, state_d;
  logic [10:0] idx_q, idx_d;
  logic        wslot_q, wslot_d;
  logic        rslot_q, rslot_d;
  logic [1:0]  full_q, full_d;
  logic [10:0] len_q [2];
  logic [10:0] len_d [2];
  logic [15:0] drop_q, drop_d;

  logic        start, cur_slot, hdr_ok, at_max, commit, drop_inc, wr_req, ack_fire;
  logic [10:0] cur_idx;
  logic [7:0]  mac_byte;

  // COMMIT doubles as IDLE for a new frame, which already targets the next slot.
  assign start    = (state_q == IDLE) || (state_q == COMMIT);
  assign cur_slot = (state_q == COMMIT) ? ~wslot_q : wslot_q;
  assign cur_idx  = start ? 11'd0 : idx_q;
  assign at_max   = (cur_idx == MaxLen);

  always_comb begin
    mac_byte = MAC[7:0];
    case (cur_idx[2:0])
      3'd0:    mac_byte = MAC[47:40];
      3'd1:    mac_byte = MAC[39:32];
      3'd2:    mac_byte = MAC[31:24];
      3'd3:    mac_byte = MAC[23:16];
      3'd4:    mac_byte = MAC[15:8];
      default: mac_byte = MAC[7:0];
    endcase
  end

  assign hdr_ok = (rxd == mac_byte) || (rxd == 8'hFF);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wslot_d  = wslot_q;
    commit   = 1'b0;
    drop_inc = 1'b0;
    wr_req   = 1'b0;
    case (state_q)
      IDLE, COMMIT: begin
        if (state_q == COMMIT) begin
          commit  = 1'b1;
          wslot_d = ~wslot_q;
          idx_d   = '0;
          state_d = IDLE;
        end
        if (rxdv) begin
          if (full_q[cur_slot]) begin
            state_d  = DROP;
            drop_inc = 1'b1;
          end else begin
            wr_req = 1'b1;
            idx_d  = 11'd1;
            if (hdr_ok) begin
              state_d = HDR;
            end else begin
              state_d  = DROP;
              drop_inc = 1'b1;
            end
          end
        end
      end
      HDR: begin
        if (rxe) begin
          state_d  = IDLE;
          idx_d    = '0;
          drop_inc = 1'b1;
        end else if (rxdv) begin
          if (at_max || !hdr_ok) begin
            wr_req   = !at_max;
            state_d  = DROP;
            drop_inc = 1'b1;
          end else begin
            wr_req = 1'b1;
            idx_d  = idx_q + 11'd1;
            if (idx_q == 11'd5) state_d = BODY;
          end
        end
      end
      BODY: begin
        if (rxe) begin
          if (idx_q >= MinLen) begin
            state_d = COMMIT;
          end else begin
            state_d  = IDLE;
            idx_d    = '0;
            drop_inc = 1'b1;
          end
        end else if (rxdv) begin
          if (at_max) begin
            state_d  = DROP;
            drop_inc = 1'b1;
          end else begin
            wr_req = 1'b1;
            idx_d  = idx_q + 11'd1;
          end
        end
      end
      DROP: begin
        if (rxe) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // A commit always lands in the slot the consumer is not holding, so both can update at once.
  always_comb begin
    ack_fire = frame_ack && full_q[rslot_q];
    full_d   = full_q;
    len_d    = len_q;
    rslot_d  = rslot_q ^ ack_fire;
    if (ack_fire) full_d[rslot_q] = 1'b0;
    if (commit) begin
      full_d[wslot_q] = 1'b1;
      len_d[wslot_q]  = idx_q;
    end
    drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge c or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      wslot_q  <= 1'b0;
      rslot_q  <= 1'b0;
      full_q   <= '0;
      len_q[0] <= '0;
      len_q[1] <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wslot_q  <= wslot_d;
      rslot_q  <= rslot_d;
      full_q   <= full_d;
      len_q[0] <= len_d[0];
      len_q[1] <= len_d[1];
      drop_q   <= drop_d;
    end
  end

  // Reset gates the combinational write path so nothing reaches the RAM while held.
  assign wr_en       = wr_req && rst;
  assign wr_addr     = wr_en ? {cur_slot, cur_idx} : 12'd0;
  assign wr_data     = wr_en ? rxd : 8'd0;
  assign frame_valid = full_q[rslot_q];
  assign frame_slot  = rslot_q;
  assign frame_len   = len_q[rslot_q];
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// Randomized self-checking bench for eth_rx_dispatch against a frame-level model
// of the two-slot buffer, address/length filtering and drop counting.
module tb_eth_rx_dispatch;

  localparam logic [47:0] MAC     = 48'h02_00_00_00_00_01;
  localparam int          MAX_LEN = 1522;
  localparam int          MIN_LEN = 64;

  logic        c = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rxd = 8'd0;
  logic        rxdv = 1'b0;
  logic        rxe = 1'b0;
  logic        frame_ack = 1'b0;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        frame_valid;
  logic        frame_slot;
  logic [10:0] frame_len;
  logic [15:0] drop_cnt;

  eth_rx_dispatch #(.MAC(MAC), .MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
    .c(c), .rst(rst), .rxd(rxd), .rxdv(rxdv), .rxe(rxe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_valid(frame_valid), .frame_slot(frame_slot), .frame_len(frame_len),
    .frame_ack(frame_ack), .drop_cnt(drop_cnt)
  );

  always #5 c = ~c;

  int tests = 0;
  int fails = 0;

  logic [7:0]  frm[$];
  logic [7:0]  fa[$];
  logic [7:0]  fb[$];
  logic [19:0] exp_wr[$];
  logic [19:0] got_wr[$];
  bit          m_full[2];
  int          m_len[2];
  int          m_ws, m_rs, m_drop;
  logic        fv_commit, fv_after;

  always @(negedge c) if (rst && wr_en) got_wr.push_back({wr_addr, wr_data});

  function automatic logic [7:0] mac_byte(int i);
    logic [47:0] m = MAC;
    return m[47-8*i -: 8];
  endfunction

  function automatic int wr_diff();
    int d = 0;
    int n = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
    d = (got_wr.size() > exp_wr.size()) ? got_wr.size() - exp_wr.size() : exp_wr.size() - got_wr.size();
    for (int i = 0; i < n; i++) if (got_wr[i] !== exp_wr[i]) d++;
    return d;
  endfunction

  // kind: 0 station MAC, 1 broadcast, 2 other unicast, 3 one corrupted header byte
  task automatic build_frame(input int n, input int kind);
    frm.delete();
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (i < 6) begin
        case (kind)
          1:       b = 8'hFF;
          2:       b = (i == 5) ? 8'h02 : mac_byte(i);
          default: b = mac_byte(i);
        endcase
      end
      frm.push_back(b);
    end
    if (kind == 3) frm[$urandom_range(0, (n < 6) ? n - 1 : 5)] = 8'h55;
  endtask

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0; m_len[0] = 0; m_len[1] = 0;
    m_ws = 0; m_rs = 0; m_drop = 0;
  endtask

  task automatic model_drop();
    if (m_drop < 65535) m_drop++;
  endtask

  task automatic model_frame();
    int n = frm.size();
    bit ok = 1;
    if (m_full[m_ws]) begin
      model_drop();
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (i >= MAX_LEN) begin ok = 0; break; end
      exp_wr.push_back({1'(m_ws), 11'(i), frm[i]});
      if (i < 6 && frm[i] != mac_byte(i) && frm[i] != 8'hFF) begin ok = 0; break; end
    end
    if (n < MIN_LEN) ok = 0;
    if (!ok) model_drop();
    else begin
      m_full[m_ws] = 1; m_len[m_ws] = n; m_ws ^= 1;
    end
  endtask

  task automatic drive_bytes();
    foreach (frm[i]) begin
      @(posedge c); #1;
      rxe = 1'b0; rxdv = 1'b1; rxd = frm[i];
    end
  endtask

  task automatic pulse_rxe();
    @(posedge c); #1;
    rxdv = 1'b0; rxd = 8'd0; rxe = 1'b1;
  endtask

  task automatic send_frame(input bit ack_at_commit);
    bit ack_ok = m_full[m_rs];
    got_wr.delete(); exp_wr.delete();
    drive_bytes();
    pulse_rxe();
    @(posedge c); #1;
    rxe = 1'b0;
    frame_ack = ack_at_commit;
    @(negedge c); fv_commit = frame_valid;
    @(posedge c); #1;
    frame_ack = 1'b0;
    @(negedge c); fv_after = frame_valid;
    model_frame();
    if (ack_at_commit && ack_ok) begin m_full[m_rs] = 0; m_rs ^= 1; end
  endtask

  task automatic do_ack();
    @(posedge c); #1 frame_ack = 1'b1;
    @(posedge c); #1 frame_ack = 1'b0;
    if (m_full[m_rs]) begin m_full[m_rs] = 0; m_rs ^= 1; end
  endtask

  task automatic test_reset();
    rst = 1'b0; rxdv = 1'b1; rxd = 8'hA5;
    repeat (3) @(posedge c);
    #1;
    tests++; if ({wr_en, wr_addr, wr_data} !== 21'd0) begin fails++; $display("[TB] FAIL reset_write: got %b/%h/%h, expected 0/000/00", wr_en, wr_addr, wr_data); end
    tests++; if ({frame_valid, frame_slot, frame_len} !== 13'd0) begin fails++; $display("[TB] FAIL reset_frame: got %b/%b/%0d, expected 0/0/0", frame_valid, frame_slot, frame_len); end
    tests++; if (drop_cnt !== 16'd0) begin fails++; $display("[TB] FAIL reset_drop: got %0d, expected 0", drop_cnt); end
    rxdv = 1'b0;
    @(posedge c); #1 rst = 1'b1;
    model_reset();
    pulse_rxe();
    @(posedge c); #1 rxe = 1'b0;
    repeat (2) @(posedge c);
    #1;
    tests++; if ({drop_cnt, frame_valid} !== 17'd0) begin fails++; $display("[TB] FAIL idle_rxe: got drop %0d valid %b, expected 0/0", drop_cnt, frame_valid); end
  endtask

  task automatic test_basic();
    build_frame(64, 0);
    send_frame(1'b0);
    tests++; if (got_wr.size() !== 64) begin fails++; $display("[TB] FAIL basic_wr_count: got %0d, expected 64", got_wr.size()); end
    tests++; if (wr_diff() !== 0) begin fails++; $display("[TB] FAIL basic_wr_data: %0d entries differ from model", wr_diff()); end
    if (got_wr.size() == 64) begin
      tests++; if (got_wr[0][19:8] !== 12'h000 || got_wr[63][19:8] !== 12'h03F) begin fails++; $display("[TB] FAIL basic_addr_range: got %h..%h, expected 000..03f", got_wr[0][19:8], got_wr[63][19:8]); end
    end
    tests++; if (fv_commit !== 1'b0 || fv_after !== 1'b1) begin fails++; $display("[TB] FAIL basic_valid_timing: got commit %b after %b, expected 0/1", fv_commit, fv_after); end
    tests++; if (frame_slot !== 1'b0 || frame_len !== 11'd64) begin fails++; $display("[TB] FAIL basic_present: got slot %b len %0d, expected 0/64", frame_slot, frame_len); end
    do_ack();
    #1;
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_ack: got valid %b, expected 0", frame_valid); end
  endtask

  task automatic test_filter();
    build_frame(100, 1);
    send_frame(1'b0);
    tests++; if (wr_diff() !== 0) begin fails++; $display("[TB] FAIL bcast_wr: %0d entries differ from model", wr_diff()); end
    build_frame(64, 2);
    send_frame(1'b0);
    tests++; if (wr_diff() !== 0) begin fails++; $display("[TB] FAIL other_wr: %0d entries differ from model", wr_diff()); end
    tests++; if (frame_valid !== 1'b1 || frame_len !== 11'd100) begin fails++; $display("[TB] FAIL bcast_len: got valid %b len %0d, expected 1/100", frame_valid, frame_len); end
    tests++; if (drop_cnt !== 16'd1) begin fails++; $display("[TB] FAIL filter_drop: got %0d, expected 1", drop_cnt); end
    repeat (2) do_ack();
  endtask

  task automatic test_full();
    int d0 = m_drop;
    for (int k = 0; k < 3; k++) begin
      build_frame(64, 0);
      send_frame(1'b0);
      tests++; if (wr_diff() !== 0) begin fails++; $display("[TB] FAIL full_wr%0d: %0d entries differ from model", k, wr_diff()); end
    end
    tests++; if (got_wr.size() !== 0) begin fails++; $display("[TB] FAIL full_third_writes: got %0d, expected 0", got_wr.size()); end
    tests++; if (drop_cnt !== 16'(d0 + 1) || frame_slot !== 1'b0) begin fails++; $display("[TB] FAIL full_drop: got drop %0d slot %b, expected %0d/0", drop_cnt, frame_slot, d0 + 1); end
    do_ack();
    #1;
    tests++; if (frame_valid !== 1'b1 || frame_slot !== 1'b1) begin fails++; $display("[TB] FAIL full_next: got valid %b slot %b, expected 1/1", frame_valid, frame_slot); end
    repeat (2) do_ack();
  endtask

  task automatic test_ack_commit();
    build_frame(64, 0);
    send_frame(1'b0);
    tests++; if (frame_valid !== 1'b1 || frame_slot !== 1'b0) begin fails++; $display("[TB] FAIL ackc_first: got valid %b slot %b, expected 1/0", frame_valid, frame_slot); end
    build_frame(80, 0);
    send_frame(1'b1);
    tests++; if (frame_valid !== 1'b1 || frame_slot !== 1'b1 || frame_len !== 11'd80) begin fails++; $display("[TB] FAIL ackc_both: got valid %b slot %b len %0d, expected 1/1/80", frame_valid, frame_slot, frame_len); end
    do_ack();
    #1;
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("[TB] FAIL ackc_slot0_freed: got valid %b, expected 0", frame_valid); end
    repeat (2) do_ack();
  endtask

  task automatic test_length();
    build_frame(60, 0);
    send_frame(1'b0);
    tests++; if (got_wr.size() !== 60 || wr_diff() !== 0) begin fails++; $display("[TB] FAIL runt_wr: got %0d writes (%0d differ), expected 60", got_wr.size(), wr_diff()); end
    build_frame(1600, 0);
    send_frame(1'b0);
    tests++; if (got_wr.size() !== MAX_LEN || wr_diff() !== 0) begin fails++; $display("[TB] FAIL long_wr: got %0d writes (%0d differ), expected %0d", got_wr.size(), wr_diff(), MAX_LEN); end
    if (got_wr.size() > 0) begin
      tests++; if (got_wr[$][18:8] !== 11'h5F1) begin fails++; $display("[TB] FAIL long_last_addr: got %h, expected 5f1", got_wr[$][18:8]); end
    end
    tests++; if (drop_cnt !== 16'(m_drop) || frame_valid !== 1'b0) begin fails++; $display("[TB] FAIL length_drop: got drop %0d valid %b, expected %0d/0", drop_cnt, frame_valid, m_drop); end
  endtask

  task automatic test_back_to_back();
    build_frame(64, 0); fa = frm;
    build_frame(70, 1); fb = frm;
    got_wr.delete(); exp_wr.delete();
    frm = fa; drive_bytes(); pulse_rxe();
    frm = fb; drive_bytes(); pulse_rxe();
    @(posedge c); #1 rxe = 1'b0;
    repeat (2) @(posedge c);
    #1;
    frm = fa; model_frame();
    frm = fb; model_frame();
    tests++; if (wr_diff() !== 0) begin fails++; $display("[TB] FAIL b2b_wr: %0d entries differ from model", wr_diff()); end
    tests++; if (frame_slot !== 1'(m_rs) || frame_len !== 11'd64) begin fails++; $display("[TB] FAIL b2b_first: got slot %b len %0d, expected %0d/64", frame_slot, frame_len, m_rs); end
    do_ack();
    #1;
    tests++; if (frame_valid !== 1'b1 || frame_len !== 11'd70) begin fails++; $display("[TB] FAIL b2b_second: got valid %b len %0d, expected 1/70", frame_valid, frame_len); end
    repeat (2) do_ack();
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      build_frame($urandom_range(40, 140), $urandom_range(0, 3));
      send_frame($urandom_range(0, 3) == 0);
      tests++; if (wr_diff() !== 0) begin fails++; $display("[TB] FAIL rnd%0d_wr: %0d entries differ from model", k, wr_diff()); end
      tests++; if (frame_valid !== m_full[m_rs]) begin fails++; $display("[TB] FAIL rnd%0d_valid: got %b, expected %b", k, frame_valid, m_full[m_rs]); end
      if (m_full[m_rs]) begin
        tests++; if (frame_slot !== 1'(m_rs) || frame_len !== 11'(m_len[m_rs])) begin fails++; $display("[TB] FAIL rnd%0d_present: got slot %b len %0d, expected %0d/%0d", k, frame_slot, frame_len, m_rs, m_len[m_rs]); end
      end
      tests++; if (drop_cnt !== 16'(m_drop)) begin fails++; $display("[TB] FAIL rnd%0d_drop: got %0d, expected %0d", k, drop_cnt, m_drop); end
      if ($urandom_range(0, 1) == 1) do_ack();
    end
  endtask

  task automatic test_midreset();
    repeat (2) do_ack();
    build_frame(64, 0);
    send_frame(1'b0);
    build_frame(64, 0);
    for (int i = 0; i < 30; i++) begin
      @(posedge c); #1;
      rxdv = 1'b1; rxd = frm[i];
    end
    #2 rst = 1'b0;
    #1;
    tests++; if ({wr_en, wr_addr, wr_data} !== 21'd0) begin fails++; $display("[TB] FAIL midrst_write: got %b/%h/%h, expected 0/000/00", wr_en, wr_addr, wr_data); end
    tests++; if ({frame_valid, frame_len, drop_cnt} !== 28'd0) begin fails++; $display("[TB] FAIL midrst_state: got valid %b len %0d drop %0d, expected 0/0/0", frame_valid, frame_len, drop_cnt); end
    rxdv = 1'b0;
    repeat (2) @(posedge c);
    #1 rst = 1'b1;
    model_reset();
    build_frame(64, 0);
    send_frame(1'b0);
    tests++; if (wr_diff() !== 0) begin fails++; $display("[TB] FAIL midrst_wr: %0d entries differ from model", wr_diff()); end
    tests++; if (frame_valid !== 1'b1 || frame_slot !== 1'b0 || frame_len !== 11'd64 || drop_cnt !== 16'd0) begin fails++; $display("[TB] FAIL midrst_clean: got valid %b slot %b len %0d drop %0d, expected 1/0/64/0", frame_valid, frame_slot, frame_len, drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_filter();
    test_full();
    test_ack_commit();
    test_length();
    test_back_to_back();
    test_random();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    fails++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
